// File: rtl/exc_seq.sv
// Exception/ERET redirect sequencer: flushes the pipeline, waits for memory
// traffic to drain, then issues a single-cycle fetch redirect.
module exc_seq #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          DRAIN_MAX  = 255,
    parameter int          DRAIN_W    = 8,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             eret_M,
    input  logic [31:0]      epc,
    input  logic             inst_busy,
    input  logic             mem_busy,
    output logic             flush,
    output logic             stall_all,
    output logic             exl_clr,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             drain_timeout,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_REDIR
    } state_t;

    localparam logic [DRAIN_W-1:0] DRAIN_LIMIT = DRAIN_W'(DRAIN_MAX);

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;
    logic               busy;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign busy = inst_busy | mem_busy;

    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        to_d           = to_q;
        flush          = 1'b0;
        stall_all      = 1'b0;
        exl_clr        = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req | eret_M) begin
                    flush   = 1'b1;
                    exl_clr = eret_M & ~req;
                    pc_d    = req ? EXC_VECTOR : epc;
                    if (req) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                    drain_d = '0;
                    state_d = busy ? S_DRAIN : S_REDIR;
                end
            end
            S_DRAIN: begin
                flush     = 1'b1;
                stall_all = 1'b1;
                if (!busy) begin
                    state_d = S_REDIR;
                end else if (drain_q == DRAIN_LIMIT) begin
                    to_d    = 1'b1;
                    state_d = S_REDIR;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_REDIR: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Reset aborts any sequence immediately, including a pending redirect.
        if (reset) begin
            flush          = 1'b0;
            stall_all      = 1'b0;
            exl_clr        = 1'b0;
            redirect_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign redirect_pc   = pc_q;
    assign exc_count     = cnt_q;
    assign drain_timeout = to_q;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: two instances (default and short-drain/2-bit count)
// checked every cycle against a cycle-count based reference model.
module tb_exc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        eret_M;
    logic [31:0] epc;
    logic        inst_busy;
    logic        mem_busy;

    logic [1:0]  flush_w, stall_w, exl_w, rv_w, to_w;
    logic [31:0] pc_w [2];
    logic [15:0] exc0;
    logic [1:0]  exc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_seq u_dut0 (
        .clk(clk), .reset(reset), .req(req), .eret_M(eret_M), .epc(epc),
        .inst_busy(inst_busy), .mem_busy(mem_busy),
        .flush(flush_w[0]), .stall_all(stall_w[0]), .exl_clr(exl_w[0]),
        .redirect_valid(rv_w[0]), .redirect_pc(pc_w[0]),
        .drain_timeout(to_w[0]), .exc_count(exc0)
    );

    exc_seq #(.DRAIN_MAX(4), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .eret_M(eret_M), .epc(epc),
        .inst_busy(inst_busy), .mem_busy(mem_busy),
        .flush(flush_w[1]), .stall_all(stall_w[1]), .exl_clr(exl_w[1]),
        .redirect_valid(rv_w[1]), .redirect_pc(pc_w[1]),
        .drain_timeout(to_w[1]), .exc_count(exc1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 draining, 2 redirecting. Drain length is
    // measured from the event cycle rather than with a dedicated counter.
    localparam int DMAX [2] = '{255, 4};
    localparam int CMAX [2] = '{65535, 3};
    int          m_phase [2];
    longint      m_tev   [2];
    logic [31:0] m_pc    [2];
    int          m_exc   [2];
    bit          m_to    [2];
    longint      cyc     = 0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] <= 0;
                m_pc[i]    <= 32'h0;
                m_exc[i]   <= 0;
                m_to[i]    <= 1'b0;
            end else if (m_phase[i] == 0) begin
                if (req || eret_M) begin
                    m_pc[i]    <= req ? 32'hBFC00380 : epc;
                    m_exc[i]   <= (req && m_exc[i] < CMAX[i]) ? m_exc[i] + 1 : m_exc[i];
                    m_tev[i]   <= cyc;
                    m_phase[i] <= (inst_busy || mem_busy) ? 1 : 2;
                end
            end else if (m_phase[i] == 1) begin
                if (!(inst_busy || mem_busy)) begin
                    m_phase[i] <= 2;
                end else if (cyc - m_tev[i] - 1 == longint'(DMAX[i])) begin
                    m_to[i]    <= 1'b1;
                    m_phase[i] <= 2;
                end
            end else begin
                m_phase[i] <= 0;
            end
        end
        if (reset) started <= 1'b1;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic ev, e_fl, e_st, e_ex, e_rv;
                ev   = (m_phase[i] == 0) && (req || eret_M);
                e_fl = !reset && (ev || m_phase[i] != 0);
                e_st = !reset && (m_phase[i] == 1);
                e_ex = !reset && (m_phase[i] == 0) && eret_M && !req;
                e_rv = !reset && (m_phase[i] == 2);
                check($sformatf("flush[%0d]", i), 32'(flush_w[i]), 32'(e_fl));
                check($sformatf("stall_all[%0d]", i), 32'(stall_w[i]), 32'(e_st));
                check($sformatf("exl_clr[%0d]", i), 32'(exl_w[i]), 32'(e_ex));
                check($sformatf("redirect_valid[%0d]", i), 32'(rv_w[i]), 32'(e_rv));
                check($sformatf("redirect_pc[%0d]", i), pc_w[i], m_pc[i]);
                check($sformatf("drain_timeout[%0d]", i), 32'(to_w[i]), 32'(m_to[i]));
            end
            check("exc_count[0]", 32'(exc0), 32'(m_exc[0]));
            check("exc_count[1]", 32'(exc1), 32'(m_exc[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_left;
        bit busy_sel;
        reset = 1'b1; req = 1'b0; eret_M = 1'b0; epc = 32'h0;
        inst_busy = 1'b0; mem_busy = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_flush", 32'(flush_w), 32'h0);
        check("rst_pc", pc_w[0], 32'h0);
        check("rst_exc", 32'(exc0), 32'h0);
        step();
        reset = 1'b0;
        step();

        // Exception, no busy
        req = 1'b1;
        @(negedge clk);
        check("exc_T_flush", 32'(flush_w[0]), 32'h1);
        check("exc_T_rv", 32'(rv_w[0]), 32'h0);
        step();
        req = 1'b0;
        @(negedge clk);
        check("exc_T1_flush", 32'(flush_w[0]), 32'h1);
        check("exc_T1_rv", 32'(rv_w[0]), 32'h1);
        check("exc_T1_pc", pc_w[0], 32'hBFC00380);
        check("exc_T1_cnt", 32'(exc0), 32'h1);
        step();
        @(negedge clk);
        check("exc_T2_rv", 32'(rv_w[0]), 32'h0);
        check("exc_T2_flush", 32'(flush_w[0]), 32'h0);

        // ERET, no busy
        step();
        epc = 32'h80001234; eret_M = 1'b1;
        @(negedge clk);
        check("eret_T_exl", 32'(exl_w[0]), 32'h1);
        step();
        eret_M = 1'b0;
        @(negedge clk);
        check("eret_T1_exl", 32'(exl_w[0]), 32'h0);
        check("eret_T1_rv", 32'(rv_w[0]), 32'h1);
        check("eret_T1_pc", pc_w[0], 32'h80001234);
        check("eret_T1_cnt", 32'(exc0), 32'h1);
        step();

        // Drain with mem_busy; extra req during drain is ignored
        req = 1'b1; mem_busy = 1'b1;
        step();
        step();
        step();
        req = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        check("drain_T3_stall", 32'(stall_w[0]), 32'h1);
        check("drain_T3_rv", 32'(rv_w[0]), 32'h0);
        step();
        @(negedge clk);
        check("drain_T4_rv", 32'(rv_w[0]), 32'h1);
        check("drain_T4_stall", 32'(stall_w[0]), 32'h0);
        check("drain_T4_to", 32'(to_w[0]), 32'h0);
        check("drain_T4_cnt", 32'(exc0), 32'h2);
        step();

        // Drain timeout on the DRAIN_MAX=4 instance
        req = 1'b1; inst_busy = 1'b1;
        step();
        req = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("to_T5_rv", 32'(rv_w[1]), 32'h0);
        check("to_T5_to", 32'(to_w[1]), 32'h0);
        step();
        @(negedge clk);
        check("to_T6_rv", 32'(rv_w[1]), 32'h1);
        check("to_T6_to", 32'(to_w[1]), 32'h1);
        check("to_T6_dut0_stall", 32'(stall_w[0]), 32'h1);
        inst_busy = 1'b0;
        step();
        step();

        // Simultaneous req and ERET
        req = 1'b1; eret_M = 1'b1; epc = 32'h12345678;
        @(negedge clk);
        check("both_T_exl", 32'(exl_w), 32'h0);
        step();
        req = 1'b0; eret_M = 1'b0;
        @(negedge clk);
        check("both_T1_pc", pc_w[1], 32'hBFC00380);
        check("both_T1_cnt0", 32'(exc0), 32'h4);
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        @(negedge clk);
        check("sat_cnt1", 32'(exc1), 32'h3);
        check("sat_cnt0", 32'(exc0), 32'h5);
        check("sticky_to", 32'(to_w[1]), 32'h1);
        step();

        // Reset during DRAIN
        req = 1'b1; mem_busy = 1'b1;
        step();
        req = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rstd_flush", 32'(flush_w), 32'h0);
        check("rstd_rv", 32'(rv_w), 32'h0);
        step();
        reset = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        check("rstd_after_rv", 32'(rv_w), 32'h0);
        check("rstd_after_stall", 32'(stall_w), 32'h0);
        check("rstd_after_pc", pc_w[0], 32'h0);
        check("rstd_after_to", 32'(to_w[1]), 32'h0);
        check("rstd_after_cnt", 32'(exc0), 32'h0);
        step();

        // Randomized traffic
        busy_left = 0;
        busy_sel  = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            reset  = ($urandom_range(0, 299) == 0);
            req    = ($urandom_range(0, 7) == 0);
            eret_M = ($urandom_range(0, 7) == 0);
            epc    = $urandom;
            if (n == 1500) begin
                busy_left = 270;
                busy_sel  = 1'b0;
            end else if (busy_left == 0 && $urandom_range(0, 9) == 0) begin
                busy_left = $urandom_range(1, 12);
                busy_sel  = 1'($urandom_range(0, 1));
            end
            inst_busy = (busy_left > 0) && !busy_sel;
            mem_busy  = ((busy_left > 0) && busy_sel) || ($urandom_range(0, 15) == 0);
            if (busy_left > 0) busy_left--;
            if (n >= 1500 && n < 1775) begin
                reset = 1'b0;
            end
            step();
        end
        reset = 1'b0; req = 1'b0; eret_M = 1'b0;
        inst_busy = 1'b0; mem_busy = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception/ERET redirect sequencer between the `cp0` block and the fetch stage. It watches `cp0`'s `req` output and the M-stage ERET, then flushes the pipeline and pulses `EXLClr` back to `cp0`. It waits for outstanding instruction and data memory transactions to drain, then issues a single one-cycle PC redirect, either to the exception vector or to `epc`. It also keeps a saturating count of exceptions taken and flags drains that time out.

## Interface
- `EXC_VECTOR`, 32'hBFC00380: redirect target on exception/interrupt.
- `DRAIN_MAX`, 255: maximum cycles spent in DRAIN before forced redirect; range 1..2^DRAIN_W-1.
- `DRAIN_W`, 8: width of drain cycle counter.
- `CNT_W`, 16: width of `exc_count`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  exception/interrupt request from `cp0` (level, M stage).
- `eret_M`  in  1  ERET instruction valid in M stage.
- `epc`  in  32  current EPC from `cp0`.
- `inst_busy`  in  1  instruction-memory request outstanding.
- `mem_busy`  in  1  data-memory request outstanding.
- `flush`  out  1  kill all pipeline stages F..M; suppress M-stage writeback and memory writes.
- `stall_all`  out  1  freeze PC and pipeline registers.
- `exl_clr`  out  1  EXLClr to `cp0`.
- `redirect_valid`  out  1  one-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc`  out  32  latched redirect target.
- `drain_timeout`  out  1  sticky; set when DRAIN reaches `DRAIN_MAX`.
- `exc_count`  out  CNT_W  number of `req` events accepted, saturating.

## Operation
- States: IDLE, DRAIN, REDIR. The state is held in registers; reset forces IDLE.
- **IDLE, event accepted:** an event is `req | eret_M` while `reset` is 0.
  - `req` has priority over `eret_M`. When both are asserted, the event is treated as an exception and `exl_clr` stays 0.
  - Exception: latch `redirect_pc <= EXC_VECTOR`, and increment `exc_count` unless it is all-ones.
  - ERET only: latch `redirect_pc <= epc`, and drive `exl_clr` = 1 combinationally in that cycle.
  - `flush` = 1 combinationally in the event cycle.
  - Next state: DRAIN if `inst_busy | mem_busy`, otherwise REDIR.
- **DRAIN:**
  - `flush` = 1 and `stall_all` = 1.
  - The drain counter starts at 0 on entry and increments each DRAIN cycle.
  - Leave for REDIR when `inst_busy` and `mem_busy` are both 0.
  - Otherwise, when the counter equals `DRAIN_MAX`, set `drain_timeout` and go to REDIR anyway.
- **REDIR:**
  - `redirect_valid` = 1, `flush` = 1, `stall_all` = 0.
  - Always return to IDLE on the next cycle.
- **Outside IDLE:** `req` and `eret_M` are ignored. Those instructions are being flushed, so no latch, no count and no `exl_clr`.
- **IDLE with no event:** all outputs are 0 except `redirect_pc`, `exc_count` and `drain_timeout`, which hold.
- **Reset values:**
  - state = IDLE.
  - `redirect_pc`, `exc_count`, drain counter = 0.
  - `drain_timeout`, `redirect_valid`, `stall_all` = 0.
  - While `reset` = 1, `flush` and `exl_clr` are forced to 0.
- **Reset mid-operation:** a reset in DRAIN or REDIR aborts the sequence. No redirect pulse is issued, and every output takes its reset value from the next edge.
- `drain_timeout` is cleared only by reset.

## Timing
- Event at cycle T with both busy lines low:
  - `flush` is high in T and T+1.
  - `redirect_valid` is high in T+1.
  - IDLE again in T+2.
  - Redirect latency is 1 cycle.
- Event at T with a busy line high:
  - DRAIN occupies T+1..T+k, where T+k is the first DRAIN cycle in which both busy lines are low.
  - `redirect_valid` is high at T+k+1.
  - With a permanent busy, REDIR is at T+DRAIN_MAX+2, and `drain_timeout` rises at the same edge.
- `redirect_pc` is stable from T+1 until the next accepted event.
- `exl_clr` lasts exactly one cycle (T) per accepted ERET.
- `exc_count` updates at the edge ending T.
- Back-to-back: an event presented in the cycle after REDIR (back in IDLE) is accepted normally.

## Test plan
- **Reset, then exception, no busy:** assert `req` at T with no busy line → `flush` high at T and T+1; `redirect_valid` high at T+1 only; `redirect_pc` = 32'hBFC00380; `exc_count` = 1.
- **ERET, no busy:** set `epc` = 32'h80001234 and pulse `eret_M` at T → `exl_clr` = 1 at T only; `redirect_pc` = 32'h80001234 at T+1 with `redirect_valid` high; `exc_count` unchanged.
- **Drain with memory busy:** `req` at T with `mem_busy` held high until T+3 → DRAIN T+1..T+3 with `stall_all` = 1; `redirect_valid` high at T+4; `drain_timeout` = 0.
- **Drain timeout:** DRAIN_MAX = 4 and `inst_busy` stuck at 1, `req` at T → REDIR at T+6; `drain_timeout` = 1 and stays 1 through later events.
- **Simultaneous events and ignored events:**
  - `req` and `eret_M` together at T → vector target and `exl_clr` = 0.
  - Another `req` during DRAIN → `exc_count` is incremented only once.
- **Reset and saturation:**
  - Reset asserted in DRAIN → no `redirect_valid` pulse; all outputs 0 and state IDLE after the edge.
  - CNT_W = 2 with 5 exceptions → `exc_count` = 3.
